march_bist_ctrl: RTL and testbench

- Self-contained March C- memory BIST sequencer for one synchronous single-port SRAM.
- Owns the address counter, write-data background generation, read compare and fail logging.
- Replaces the separate counter/comparator handshake with one controller that drives the memory port directly.
- Sits between the test-access start/abort controls and the memory under test.

---
 rtl/bist_pkg.sv | 40 ++++
 rtl/bist_addr_gen.sv | 30 +++
 rtl/march_bist_ctrl.sv | 176 +++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and per-element March C- constants for the BIST controller.
package bist_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StM0,
        StM1,
        StM2,
        StM3,
        StM4,
        StM5,
        StDrain,
        StDone
    } state_e;

    localparam logic [2:0] ELEM_M0 = 3'd0;
    localparam logic [2:0] ELEM_M1 = 3'd1;
    localparam logic [2:0] ELEM_M2 = 3'd2;
    localparam logic [2:0] ELEM_M3 = 3'd3;
    localparam logic [2:0] ELEM_M4 = 3'd4;
    localparam logic [2:0] ELEM_M5 = 3'd5;

    // Bit i describes element Mi; bits 6..7 are padding so elem+1 stays in range.
    localparam logic [7:0] ELEM_UP     = 8'b0010_0111;
    localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
    localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
    localparam logic [7:0] ELEM_RD_BG  = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_BG  = 8'b0000_1010;

    function automatic logic [2:0] state_elem(input state_e s);
        logic [3:0] w_idx;
        w_idx = 4'(s) - 4'd1;
        return w_idx[2:0];
    endfunction

    function automatic logic is_march(input state_e s);
        return (s >= StM0) && (s <= StM5);
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Loadable up/down address counter with a terminal-address flag.
module bist_addr_gen #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_load_up,
    input  logic              i_en,
    input  logic              i_up,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_up ? '0 : '1;
        end else if (i_en) begin
            r_addr <= i_up ? r_addr + ADDR_W'(1) : r_addr - ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = i_up ? (r_addr == '1) : (r_addr == '0);

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer: drives one single-port SRAM, compares reads and logs failures.
module march_bist_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [FCNT_W-1:0] fail_cnt
);

    state_e            r_state, w_state_d;
    logic              r_phase, w_phase_d;
    logic              r_launch, w_launch_d;
    logic              w_clear;
    logic              w_ag_load, w_ag_load_up, w_ag_en;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;
    logic [2:0]        w_elem, w_elem_nxt;
    logic              w_march, w_up, w_has_rd, w_has_wr;
    logic              w_rd_op, w_wr_op, w_step, w_abort, w_mis;

    logic              r_cmp_vld;
    logic [DATA_W-1:0] r_cmp_exp;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic [2:0]        r_cmp_elem;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [2:0]        r_fail_elem;
    logic [FCNT_W-1:0] r_fail_cnt;

    assign w_elem     = state_elem(r_state);
    assign w_elem_nxt = w_elem + 3'd1;
    assign w_march    = is_march(r_state);
    assign w_up       = ELEM_UP[w_elem];
    assign w_has_rd   = ELEM_HAS_RD[w_elem];
    assign w_has_wr   = ELEM_HAS_WR[w_elem];

    // Read-then-write elements use r_phase to split each address over two cycles.
    assign w_rd_op = w_march && w_has_rd && (!w_has_wr || !r_phase);
    assign w_wr_op = w_march && w_has_wr && (!w_has_rd || r_phase);
    assign w_step  = w_wr_op || (w_rd_op && !w_has_wr);
    assign w_abort = abort && (w_march || (r_state == StDrain) || r_launch);

    bist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_ag_load),
        .i_load_up (w_ag_load_up),
        .i_en      (w_ag_en),
        .i_up      (w_up),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

    always_comb begin
        w_state_d    = r_state;
        w_phase_d    = r_phase;
        w_launch_d   = 1'b0;
        w_clear      = 1'b0;
        w_ag_load    = 1'b0;
        w_ag_load_up = 1'b1;
        w_ag_en      = 1'b0;
        if (w_abort) begin
            w_state_d = StIdle;
            w_phase_d = 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    // Start is taken one cycle ahead of M0 so the first write lands after edge 1.
                    if (r_launch) begin
                        w_state_d = StM0;
                        w_ag_load = 1'b1;
                    end else if (start && !abort) begin
                        w_state_d  = StIdle;
                        w_launch_d = 1'b1;
                        w_clear    = 1'b1;
                    end
                end
                StDrain: w_state_d = StDone;
                default: begin
                    if (w_rd_op && w_has_wr) begin
                        w_phase_d = 1'b1;
                    end
                    if (w_step) begin
                        w_phase_d = 1'b0;
                        if (w_last) begin
                            w_ag_load    = 1'b1;
                            w_ag_load_up = ELEM_UP[w_elem_nxt];
                            w_state_d    = (r_state == StM5) ? StDrain : state_e'(r_state + 4'd1);
                        end else begin
                            w_ag_en = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_phase  <= 1'b0;
            r_launch <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_phase  <= w_phase_d;
            r_launch <= w_launch_d;
        end
    end

    assign w_mis = (mem_rdata != r_cmp_exp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmp_vld   <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_cmp_vld  <= w_rd_op && !w_abort;
            r_cmp_exp  <= {DATA_W{ELEM_RD_BG[w_elem]}};
            r_cmp_addr <= w_addr;
            r_cmp_elem <= w_elem;
            if (w_clear) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_elem <= '0;
                r_fail_cnt  <= '0;
            end else if (r_cmp_vld && !w_abort && w_mis) begin
                if (r_fail_cnt != '1) begin
                    r_fail_cnt <= r_fail_cnt + FCNT_W'(1);
                end
                if (!r_fail) begin
                    r_fail      <= 1'b1;
                    r_fail_addr <= r_cmp_addr;
                    r_fail_elem <= r_cmp_elem;
                end
            end
        end
    end

    assign mem_we    = w_wr_op;
    assign mem_re    = w_rd_op;
    assign mem_addr  = w_march ? w_addr : '0;
    assign mem_wdata = w_wr_op ? {DATA_W{ELEM_WR_BG[w_elem]}} : '0;
    assign busy      = w_march || (r_state == StDrain);
    assign done      = (r_state == StDone);
    assign pass      = done && (r_fail_cnt == '0);
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;
    assign fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl: SRAM model with fault injection, op and result scoreboards.
module tb_march_bist_ctrl;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, mem_re;
    logic [7:0] mem_rdata;
    logic       busy, done, pass, fail;
    logic [3:0] fail_addr;
    logic [2:0] fail_elem;
    logic [7:0] fail_cnt;

    always #5 clk = ~clk;

    march_bist_ctrl #(
        .ADDR_W (4),
        .DATA_W (8),
        .FCNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_cnt  (fail_cnt)
    );

    // SRAM model; the fault distorts data on the read path only.
    logic [7:0] mem [N];
    logic       f_en = 1'b0;
    logic [3:0] f_addr = 4'd0;
    logic [7:0] f_sa0 = 8'h00;
    logic [7:0] f_sa1 = 8'h00;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) begin
            if (f_en && mem_addr == f_addr) mem_rdata <= (mem[mem_addr] & ~f_sa0) | f_sa1;
            else                            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       we;
        logic       re;
        logic [3:0] addr;
        logic [7:0] wdata;
    } io_t;

    typedef struct packed {
        logic       pass;
        logic       fail;
        logic [2:0] elem;
        logic [3:0] addr;
        logic [7:0] cnt;
    } res_t;

    io_t  op_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic io_t obs_io();
        return {busy, done, mem_we, mem_re, mem_addr, mem_wdata};
    endfunction

    function automatic res_t obs_res();
        return {pass, fail, fail_elem, fail_addr, fail_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected March C- op stream, one entry per op cycle.
    task automatic push_march();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                logic       up;
                logic [3:0] a;
                io_t        op;
                up = (e == 0) || (e == 1) || (e == 2) || (e == 5);
                a  = up ? 4'(i) : 4'(N - 1 - i);
                if (e >= 1) begin
                    op = {1'b1, 1'b0, 1'b0, 1'b1, a, 8'h00};
                    op_q.push_back(op);
                end
                if (e <= 4) begin
                    op = {1'b1, 1'b0, 1'b1, 1'b0, a, ((e == 1) || (e == 3)) ? 8'hFF : 8'h00};
                    op_q.push_back(op);
                end
            end
        end
    endtask

    task automatic run_full(input res_t exp, input int inj_cyc, input int mid_start);
        io_t o;
        io_t e;
        int  nwe;
        int  nre;
        nwe = 0;
        nre = 0;
        push_march();
        res_q.push_back(exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clear", {busy, done, fail, fail_cnt}, 32'h0);
        for (int k = 1; k <= 162; k++) begin
            start = (k == mid_start);
            if (k == inj_cyc) f_en = 1'b1;
            tick();
            o = obs_io();
            nwe += int'(mem_we);
            nre += int'(mem_re);
            if (k <= 160) begin
                e = (op_q.size() != 0) ? op_q.pop_front() : '1;
                chk($sformatf("op@%0d", k), o, e);
            end else if (k == 161) begin
                chk("drain", o, 32'h8000);
            end else begin
                chk("done@162", o, 32'h4000);
                chk("result", obs_res(), (res_q.size() != 0) ? res_q.pop_front() : '1);
            end
        end
        start = 1'b0;
        chk("we_count", nwe, 80);
        chk("re_count", nre, 80);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset_io", obs_io(), 32'h0);
        chk("reset_res", obs_res(), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Fault-free memory
        run_full({1'b1, 1'b0, 3'd0, 4'd0, 8'd0}, 0, 0);

        // Stuck-at-0 bit0 at addr 5: seen by the r1 reads of M2 and M4
        f_en = 1'b1; f_addr = 4'd5; f_sa0 = 8'h01; f_sa1 = 8'h00;
        run_full({1'b0, 1'b1, 3'd2, 4'd5, 8'd2}, 0, 0);

        // Stuck-at-1 bit3 at addr 10: seen by the r0 reads of M1, M3, M5
        f_addr = 4'd10; f_sa0 = 8'h00; f_sa1 = 8'h08;
        run_full({1'b0, 1'b1, 3'd1, 4'd10, 8'd3}, 0, 0);

        // Fault at addr 15 appearing after M4, caught only by the last M5 read
        f_en = 1'b0; f_addr = 4'd15; f_sa0 = 8'h00; f_sa1 = 8'h01;
        run_full({1'b0, 1'b1, 3'd5, 4'd15, 8'd1}, 145, 0);

        // Abort during M3 with a fault already logged in M2
        f_en = 1'b1; f_addr = 4'd5; f_sa0 = 8'h01; f_sa1 = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (90) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_io", obs_io(), 32'h0);
        chk("abort_keep", obs_res(), {1'b0, 1'b1, 3'd2, 4'd5, 8'd1});
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_io", obs_io(), 32'h0);
        chk("start_abort_keep", obs_res(), {1'b0, 1'b1, 3'd2, 4'd5, 8'd1});
        tick();
        chk("start_abort_idle", obs_io(), 32'h0);
        run_full({1'b0, 1'b1, 3'd2, 4'd5, 8'd2}, 0, 0);

        // Asynchronous reset in the middle of M1
        f_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        #2 rst = 1'b0;
        #1;
        chk("async_rst_io", obs_io(), 32'h0);
        chk("async_rst_res", obs_res(), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_idle", obs_io(), 32'h0);

        // Start pulse while busy must not disturb the run
        run_full({1'b1, 1'b0, 3'd0, 4'd0, 8'd0}, 0, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
